// File: rtl/instruction_loader.sv
// Instruction ROM loader: parses a framed byte stream (SYNC, N, N x {LO,HI}, CHK) into
// sequential imem writes from address 0 and holds the CPU in reset while loading.
module instruction_loader #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 15,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              abort_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              cpu_rst_no
);

    // Counter must hold 2**ADDR_W (N=0) as well as any 8-bit count.
    localparam int CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'({1'b1, {ADDR_W{1'b0}}});

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic [2:0]        state;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        lo_byte;
    logic [7:0]        csum;
    logic              error_q;
    logic              accept;

    always_comb begin
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        case (state)
            S_IDLE:                      byte_ready_o = 1'b1;
            S_COUNT, S_LO, S_HI, S_CHECK: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
            end
            S_WRITE:                     busy_o = 1'b1;
            default: begin
                byte_ready_o = 1'b0;
                busy_o       = 1'b0;
            end
        endcase
    end

    assign accept     = byte_valid_i & byte_ready_o;
    assign we_o       = (state == S_WRITE);
    assign done_o     = (state == S_DONE);
    assign waddr_o    = waddr;
    assign wdata_o    = wdata;
    assign error_o    = error_q;
    assign cpu_rst_no = ~(busy_o | error_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            remaining <= '0;
            waddr     <= '0;
            wdata     <= '0;
            lo_byte   <= '0;
            csum      <= '0;
            error_q   <= 1'b0;
        end else if (abort_i && (state != S_IDLE)) begin
            // Abort wins over any byte presented in the same cycle.
            state   <= S_IDLE;
            error_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && (byte_i == SYNC_BYTE)) begin
                        state   <= S_COUNT;
                        error_q <= 1'b0;
                        csum    <= '0;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        remaining <= (byte_i == 8'h00) ? FULL_CNT
                                                       : {{(CNT_W-8){1'b0}}, byte_i};
                        waddr     <= '0;
                        csum      <= csum ^ byte_i;
                        state     <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        lo_byte <= byte_i;
                        csum    <= csum ^ byte_i;
                        state   <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        wdata <= {byte_i[DATA_W-9:0], lo_byte};
                        csum  <= csum ^ byte_i;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    waddr     <= waddr + 1'b1;
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == CNT_W'(1)) ? S_CHECK : S_LO;
                end
                S_CHECK: begin
                    if (accept) begin
                        if (byte_i == csum) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
